// File: rtl/agex_exec_mdu_stage.sv
// agex_exec_mdu_stage: execute stage with ALU, branch/jump resolution and an iterative multiply/divide unit
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_ready           decode-side handshake; in_op, in_use_imm, in_pc, in_rs1, in_rs2,
//                               in_imm, in_rd, in_tag describe the instruction
//   out_valid/out_ready         memory-side handshake; out_result, out_rd, out_wr_en, out_pc, out_tag
//   br_redirect, br_target      one-cycle redirect to fetch/decode on a taken branch or jump
module agex_exec_mdu_stage #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 32,
    parameter int MDU_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic             in_use_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [4:0]       in_rd,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output logic             out_wr_en,
    output logic [XLEN-1:0]  out_pc,
    output logic [TAG_W-1:0] out_tag,
    output logic             br_redirect,
    output logic [XLEN-1:0]  br_target
);
    localparam int SW = $clog2(XLEN);
    localparam logic [SW:0] STEPS = (SW+1)'(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [XLEN-1:0]   b, alu, target, jr_sum;
    logic              taken, wr_en, accept, is_mdu, out_free, md_fin, md_load;
    logic [2*XLEN-1:0] p, p_nx;
    logic [XLEN-1:0]   md_b, md_pc, md_result;
    logic [1:0]        md_op;
    logic [4:0]        md_rd;
    logic [TAG_W-1:0]  md_tag;
    logic [SW:0]       cnt;
    logic [XLEN:0]     m_sum, r_sh;
    logic [XLEN+1:0]   d_try;

    assign b         = in_use_imm ? in_imm : in_rs2;
    assign jr_sum    = in_rs1 + in_imm;
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = !reset && state == IDLE && out_free && !br_redirect;
    assign accept    = in_valid && in_ready;
    assign is_mdu    = (MDU_EN != 0) && in_op[4:2] == 3'b110;
    assign md_fin    = state == BUSY && cnt == STEPS;
    assign md_load   = out_free && (md_fin || state == DONE);
    // p holds {high, low}: product for multiply, {remainder, quotient} for divide;
    // op bit 0 picks the high half (MULHU, REMU)
    assign md_result = md_op[0] ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];

    always_comb begin
        alu    = '0;
        taken  = 1'b0;
        target = in_pc + in_imm;
        case (in_op)
            5'd1:  alu = in_rs1 + b;
            5'd2:  alu = in_rs1 - b;
            5'd3:  alu = in_rs1 & b;
            5'd4:  alu = in_rs1 | b;
            5'd5:  alu = in_rs1 ^ b;
            5'd6:  alu = in_rs1 << b[SW-1:0];
            5'd7:  alu = in_rs1 >> b[SW-1:0];
            5'd8:  alu = $unsigned($signed(in_rs1) >>> b[SW-1:0]);
            5'd9:  alu = XLEN'($signed(in_rs1) < $signed(b));
            5'd10: alu = XLEN'(in_rs1 < b);
            5'd16: taken = in_rs1 == in_rs2;
            5'd17: taken = in_rs1 != in_rs2;
            5'd18: taken = $signed(in_rs1) < $signed(in_rs2);
            5'd19: taken = $signed(in_rs1) >= $signed(in_rs2);
            5'd20: taken = in_rs1 < in_rs2;
            5'd21: taken = in_rs1 >= in_rs2;
            5'd22: begin
                taken = 1'b1;
                alu   = in_pc + XLEN'(4);
            end
            5'd23: begin
                taken  = 1'b1;
                alu    = in_pc + XLEN'(4);
                target = {jr_sum[XLEN-1:1], 1'b0};
            end
            default: alu = '0;
        endcase
        wr_en = in_rd != 5'd0 && (in_op inside {[5'd1:5'd10], [5'd22:5'd27]});
    end

    // One radix-2 step: shift-add multiply or restoring divide.
    // A zero divisor never borrows, which naturally yields all-ones / dividend.
    always_comb begin
        m_sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, md_b} : '0);
        r_sh  = p[2*XLEN-1:XLEN-1];
        d_try = {1'b0, r_sh} - {2'b0, md_b};
        p_nx  = !md_op[1] ? {m_sum, p[XLEN-1:1]} :
                d_try[XLEN+1] ? {r_sh[XLEN-1:0], p[XLEN-2:0], 1'b0} :
                {d_try[XLEN-1:0], p[XLEN-2:0], 1'b1};
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && accept && is_mdu) state_nx = BUSY;
        if (md_load) state_nx = IDLE;
        else if (md_fin) state_nx = DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            p      <= '0;
            md_b   <= '0;
            md_op  <= '0;
            md_rd  <= '0;
            md_pc  <= '0;
            md_tag <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (accept && is_mdu) begin
                p      <= {{XLEN{1'b0}}, in_rs1};
                md_b   <= b;
                md_op  <= in_op[1:0];
                md_rd  <= in_rd;
                md_pc  <= in_pc;
                md_tag <= in_tag;
                cnt    <= '0;
            end else if (state == BUSY && !md_fin) begin
                p   <= p_nx;
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_wr_en   <= 1'b0;
            out_pc      <= '0;
            out_tag     <= '0;
            br_redirect <= 1'b0;
            br_target   <= '0;
        end else begin
            br_redirect <= accept && taken;
            if (accept && taken) br_target <= target;
            if (accept && !is_mdu) begin
                out_valid  <= 1'b1;
                out_result <= alu;
                out_rd     <= in_rd;
                out_wr_en  <= wr_en;
                out_pc     <= in_pc;
                out_tag    <= in_tag;
            end else if (md_load) begin
                out_valid  <= 1'b1;
                out_result <= md_result;
                out_rd     <= md_rd;
                out_wr_en  <= md_rd != 5'd0;
                out_pc     <= md_pc;
                out_tag    <= md_tag;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_agex_exec_mdu_stage.sv
// tb_agex_exec_mdu_stage: table-driven scoreboard bench for the execute/MDU stage
module tb_agex_exec_mdu_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_use_imm = 1'b0;
    logic [4:0]  in_op = '0, in_rd = '0;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_tag = '0;
    logic        out_valid, out_ready = 1'b1, out_wr_en, br_redirect;
    logic [31:0] out_result, out_pc, out_tag, br_target;
    logic [4:0]  out_rd;

    typedef struct {
        logic [4:0]  op;
        logic        ui;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        wr, redir;
        logic [31:0] tgt;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] pc, tag;
    } exp_t;

    exp_t  sb[$];
    vec_t  tv[$];
    int    tests = 0, fails = 0;
    int    tag = 100;
    longint acc_t;

    agex_exec_mdu_stage #(.XLEN(32), .TAG_W(32), .MDU_EN(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_use_imm(in_use_imm),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wr_en(out_wr_en), .out_pc(out_pc), .out_tag(out_tag),
        .br_redirect(br_redirect), .br_target(br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic ui, input logic [31:0] pc, a, b, imm,
                                input logic [4:0] rd, input logic [31:0] res, input logic wr, redir,
                                input logic [31:0] tgt);
        vec_t v;
        v.op = op; v.ui = ui; v.pc = pc; v.a = a; v.b = b; v.imm = imm;
        v.rd = rd; v.res = res; v.wr = wr; v.redir = redir; v.tgt = tgt;
        return v;
    endfunction

    // Scoreboard: every output transfer (seen at negedge, happens at next posedge) pops one entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got result %h tag %h, none expected", out_result, out_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("rd", out_rd, e.rd);
                chk("wr_en", out_wr_en, e.wr);
                chk("pc", out_pc, e.pc);
                chk("tag", out_tag, e.tag);
            end
        end
    end

    // Called at posedge+1; returns at the accept edge +1.
    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1; in_op = v.op; in_use_imm = v.ui; in_pc = v.pc;
        in_rs1 = v.a; in_rs2 = v.b; in_imm = v.imm; in_rd = v.rd; in_tag = tag;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{v.res, v.rd, v.wr, v.pc, tag});
        acc_t = $time;
        tag++;
        #1 in_valid = 1'b0;
        chk("redirect", br_redirect, v.redir);
        if (v.redir) begin
            chk("target", br_target, v.tgt);
            chk("in_ready_redir", in_ready, 0);
        end
        if (v.op < 5'd24) chk("out_valid_lat", out_valid, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint t0;
        int n, bad;
        tv.push_back(mk(5'd1,  0, 32'h10,  5, 7, 0, 3, 12, 1, 0, 0));
        tv.push_back(mk(5'd1,  1, 32'h14,  10, 99, 32'hFFFFFFFD, 4, 7, 1, 0, 0));
        tv.push_back(mk(5'd2,  0, 32'h18,  3, 5, 0, 5, 32'hFFFFFFFE, 1, 0, 0));
        tv.push_back(mk(5'd3,  0, 32'h1C,  32'hF0F0, 32'hFF00, 0, 6, 32'hF000, 1, 0, 0));
        tv.push_back(mk(5'd4,  0, 32'h20,  32'hF0F0, 32'hFF00, 0, 6, 32'hFFF0, 1, 0, 0));
        tv.push_back(mk(5'd5,  0, 32'h24,  32'hF0F0, 32'hFF00, 0, 6, 32'h0FF0, 1, 0, 0));
        tv.push_back(mk(5'd6,  0, 32'h28,  3, 33, 0, 7, 6, 1, 0, 0));
        tv.push_back(mk(5'd7,  1, 32'h2C,  32'h80000000, 0, 4, 8, 32'h08000000, 1, 0, 0));
        tv.push_back(mk(5'd8,  1, 32'h30,  32'h80000000, 0, 4, 9, 32'hF8000000, 1, 0, 0));
        tv.push_back(mk(5'd9,  0, 32'h34,  32'hFFFFFFFF, 1, 0, 10, 1, 1, 0, 0));
        tv.push_back(mk(5'd10, 0, 32'h38,  32'hFFFFFFFF, 1, 0, 11, 0, 1, 0, 0));
        tv.push_back(mk(5'd1,  0, 32'h3C,  1, 1, 0, 0, 2, 0, 0, 0));
        tv.push_back(mk(5'd0,  0, 32'h40,  9, 9, 0, 12, 0, 0, 0, 0));
        tv.push_back(mk(5'd11, 0, 32'h44,  9, 9, 0, 13, 0, 0, 0, 0));
        tv.push_back(mk(5'd16, 0, 32'h100, 3, 3, 32'h20, 5, 0, 0, 1, 32'h120));
        tv.push_back(mk(5'd17, 0, 32'h104, 3, 3, 32'h20, 5, 0, 0, 0, 0));
        tv.push_back(mk(5'd18, 0, 32'h200, 32'hFFFFFFFF, 1, 32'hFFFFFFF8, 5, 0, 0, 1, 32'h1F8));
        tv.push_back(mk(5'd19, 0, 32'h204, 32'hFFFFFFFF, 1, 32'h40, 5, 0, 0, 0, 0));
        tv.push_back(mk(5'd20, 0, 32'h208, 32'hFFFFFFFF, 1, 32'h40, 5, 0, 0, 0, 0));
        tv.push_back(mk(5'd21, 0, 32'h500, 32'hFFFFFFFF, 1, 32'h10, 5, 0, 0, 1, 32'h510));
        tv.push_back(mk(5'd22, 0, 32'h300, 0, 0, 32'h40, 1, 32'h304, 1, 1, 32'h340));
        tv.push_back(mk(5'd23, 0, 32'h400, 32'h1001, 0, 32'h10, 1, 32'h404, 1, 1, 32'h1010));
        tv.push_back(mk(5'd25, 0, 32'h600, 32'hFFFFFFFF, 2, 0, 14, 1, 1, 0, 0));
        tv.push_back(mk(5'd26, 0, 32'h604, 100, 7, 0, 14, 14, 1, 0, 0));
        tv.push_back(mk(5'd27, 0, 32'h608, 100, 7, 0, 14, 2, 1, 0, 0));
        tv.push_back(mk(5'd26, 0, 32'h60C, 7, 0, 0, 14, 32'hFFFFFFFF, 1, 0, 0));
        tv.push_back(mk(5'd27, 0, 32'h610, 7, 0, 0, 14, 7, 1, 0, 0));
        tv.push_back(mk(5'd24, 1, 32'h614, 6, 0, 7, 15, 42, 1, 0, 0));
        tv.push_back(mk(5'd24, 0, 32'h618, 3, 4, 0, 0, 12, 0, 0, 0));

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_redirect", br_redirect, 0);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_result", out_result, 0);
        chk("rst_target", br_target, 0);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("post_rst_ready", in_ready, 1);

        foreach (tv[i]) send(tv[i]);
        drain();

        // Back-to-back single-cycle ops: four accepts in four consecutive edges
        send(mk(5'd1, 0, 32'h700, 1, 2, 0, 3, 3, 1, 0, 0));
        t0 = acc_t;
        for (int i = 0; i < 3; i++) send(mk(5'd1, 0, 32'h704 + 4 * i, i, 10, 0, 3, 10 + i, 1, 0, 0));
        chk("throughput", 32'(acc_t - t0), 30);
        drain();

        // MUL latency: out_valid at accept+33 edges, in_ready low throughout
        send(mk(5'd24, 0, 32'h800, 32'hFFFFFFFF, 2, 0, 20, 32'hFFFFFFFE, 1, 0, 0));
        n = 0;
        bad = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) bad++;
            @(posedge clk);
            #1 n++;
        end
        chk("mul_latency", n, 33);
        chk("busy_in_ready", bad, 0);
        drain();

        // Backpressure: output held stable, next op not accepted, then drain+accept together
        out_ready = 1'b0;
        send(mk(5'd1, 0, 32'h900, 20, 22, 0, 21, 42, 1, 0, 0));
        in_valid = 1'b1; in_op = 5'd1; in_rs1 = 1; in_rs2 = 2;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, 42);
            chk("hold_tag", out_tag, tag - 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(mk(5'd1, 0, 32'h904, 1, 2, 0, 21, 3, 1, 0, 0));
        drain();

        // MDU finishing into a stalled consumer: result held until out_ready
        out_ready = 1'b0;
        send(mk(5'd25, 0, 32'hA00, 32'hFFFFFFFF, 2, 0, 22, 1, 1, 0, 0));
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("mdu_stall_valid", out_valid, 1);
        repeat (3) begin
            @(negedge clk);
            chk("mdu_hold_result", out_result, 1);
            chk("mdu_hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset in the middle of a DIVU: no result may ever appear
        send(mk(5'd26, 0, 32'hB00, 100, 7, 0, 23, 14, 1, 0, 0));
        void'(sb.pop_back());
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 0);
        #2 reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("no_stale_result", n, 0);
        chk("after_rst_ready", in_ready, 1);
        @(posedge clk);
        #1 send(mk(5'd1, 0, 32'hB04, 1, 1, 0, 24, 2, 1, 0, 0));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
